// File: rtl/normal_flit_tx_queue_pkg.sv
// Shared flit layout and the transmit-queue state encoding used by normal_flit_tx_queue.
package types;
   typedef struct packed {
      logic [7:0]  src_id;
      logic [7:0]  dst_id;
      logic [31:0] payload;
   } flit_t;
endpackage

package packet_types;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;
endpackage

// File: rtl/normal_flit_tx_queue_flit_fifo.sv
// DEPTH-entry flit FIFO with registered occupancy; pushes when full and pops when empty are ignored.
module flit_fifo
   import types::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [$bits(flit_t)-1:0] data_i,
   output logic [$bits(flit_t)-1:0] data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   flit_t            mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
      if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= flit_t'(data_i);
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/normal_flit_tx_queue.sv
// Flit transmit queue: holds the head until acked, retransmits on timeout, drops after MAX_RETRY.
// Optional NORMAL_FLIT_TX_STATS_EN adds saturating sent/acked/dropped counters.
module normal_flit_tx_queue
   import types::*, packet_types::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic                     nocclk,
   input  logic                     rst,
   input  logic                     flit_in_valid,
   input  logic [$bits(flit_t)-1:0] flit_in,
   output logic                     flit_in_ready,
   output logic                     flit_out_valid,
   output logic [$bits(flit_t)-1:0] flit_out,
   input  logic                     flit_out_ready,
   input  logic                     ack_valid,
   output logic                     drop_pulse,
   output logic [$clog2(DEPTH):0]   count
`ifdef NORMAL_FLIT_TX_STATS_EN
   ,
   output logic [31:0]              sent_cnt,
   output logic [31:0]              acked_cnt,
   output logic [15:0]              dropped_cnt
`endif
);
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT) + 1;
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1) + 1;
   localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(ACK_TIMEOUT - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

   tx_state_t          state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               drop_q, drop_d;
   logic               pop_head, ack_hit, drop_hit;
   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;

   flit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (nocclk),
      .rst_i   (rst),
      .push_i  (flit_in_valid),
      .pop_i   (pop_head),
      .data_i  (flit_in),
      .data_o  (flit_out),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign flit_in_ready = !fifo_full;
   assign count         = fifo_count;
   assign drop_pulse    = drop_q;

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      retry_d        = retry_q;
      drop_d         = 1'b0;
      pop_head       = 1'b0;
      ack_hit        = 1'b0;
      drop_hit       = 1'b0;
      flit_out_valid = 1'b0;
      unique case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               state_d = TX_SEND;
               retry_d = '0;
            end
         end
         TX_SEND: begin
            flit_out_valid = 1'b1;
            if (flit_out_ready) begin
               state_d = TX_WAIT;
               timer_d = TIMER_INIT;
            end
         end
         TX_WAIT: begin
            // An ack arriving on the expiry cycle takes priority over retry/drop.
            if (ack_valid) begin
               ack_hit = 1'b1;
            end else if (timer_q == '0) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + RETRY_W'(1);
                  state_d = TX_SEND;
               end else begin
                  drop_hit = 1'b1;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
            if (ack_hit || drop_hit) begin
               pop_head = 1'b1;
               drop_d   = drop_hit;
               retry_d  = '0;
               state_d  = (fifo_count == CNT_W'(1)) ? TX_IDLE : TX_SEND;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         state_q <= TX_IDLE;
         timer_q <= '0;
         retry_q <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         retry_q <= retry_d;
         drop_q  <= drop_d;
      end
   end

`ifdef NORMAL_FLIT_TX_STATS_EN
   logic [31:0] sent_q, acked_q;
   logic [15:0] dropped_q;

   always_ff @(posedge nocclk or posedge rst) begin
      if (rst) begin
         sent_q    <= '0;
         acked_q   <= '0;
         dropped_q <= '0;
      end else begin
         if (flit_out_valid && flit_out_ready && sent_q != '1) sent_q <= sent_q + 32'd1;
         if (ack_hit && acked_q != '1)                        acked_q <= acked_q + 32'd1;
         if (drop_hit && dropped_q != '1)                     dropped_q <= dropped_q + 16'd1;
      end
   end

   assign sent_cnt    = sent_q;
   assign acked_cnt   = acked_q;
   assign dropped_cnt = dropped_q;
`endif
endmodule

// File: tb/tb_normal_flit_tx_queue.sv
// Self-checking bench for normal_flit_tx_queue: directed scenarios plus a randomized run,
// all compared against a timestamp/queue reference model.
module tb_normal_flit_tx_queue;
   import types::*;

   localparam int DEPTH = 4;
   localparam int T     = 4;
   localparam int MR    = 2;
   localparam int FW    = $bits(flit_t);

   logic                  nocclk = 1'b0;
   logic                  rst;
   logic                  flit_in_valid;
   flit_t                 flit_in_s;
   logic                  flit_in_ready;
   logic                  flit_out_valid;
   logic [FW-1:0]         flit_out;
   logic                  flit_out_ready;
   logic                  ack_valid;
   logic                  drop_pulse;
   logic [$clog2(DEPTH):0] count;
`ifdef NORMAL_FLIT_TX_STATS_EN
   logic [31:0] sent_cnt, acked_cnt;
   logic [15:0] dropped_cnt;
`endif

   normal_flit_tx_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
      .nocclk         (nocclk),
      .rst            (rst),
      .flit_in_valid  (flit_in_valid),
      .flit_in        (flit_in_s),
      .flit_in_ready  (flit_in_ready),
      .flit_out_valid (flit_out_valid),
      .flit_out       (flit_out),
      .flit_out_ready (flit_out_ready),
      .ack_valid      (ack_valid),
      .drop_pulse     (drop_pulse),
      .count          (count)
`ifdef NORMAL_FLIT_TX_STATS_EN
      ,
      .sent_cnt       (sent_cnt),
      .acked_cnt      (acked_cnt),
      .dropped_cnt    (dropped_cnt)
`endif
   );

   always #5 nocclk = ~nocclk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a flit queue plus the cycle numbers at which the head is
   // offered, was last handed over, and when a drop should be visible.
   int    cyc       = 0;
   flit_t m_q[$];
   int    m_offer   = -1;
   int    m_hs      = -1;
   int    m_sends   = 0;
   int    m_drop_at = -1;

   int    n_hs, n_vcyc, n_drop, last_hs_cyc;
   flit_t hs_flit;
   flit_t zf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic flit_t mk_flit(input logic [7:0] dst, input logic [31:0] pl);
      flit_t f;
      f.src_id  = 8'h11;
      f.dst_id  = dst;
      f.payload = pl;
      return f;
   endfunction

   function automatic flit_t rnd_flit();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return flit_t'(r[FW-1:0]);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_offer   = -1;
      m_hs      = -1;
      m_sends   = 0;
      m_drop_at = -1;
   endtask

   task automatic clr_stats();
      n_hs = 0; n_vcyc = 0; n_drop = 0; last_hs_cyc = -1;
   endtask

   // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
   task automatic apply_reset();
      rst = 1'b1;
      flit_in_valid = 1'b0; flit_in_s = zf; flit_out_ready = 1'b0; ack_valid = 1'b0;
      #1;
      check("rst_out_valid", 64'(flit_out_valid), 64'd0);
      check("rst_count",     64'(count),          64'd0);
      check("rst_in_ready",  64'(flit_in_ready),  64'd1);
      check("rst_drop",      64'(drop_pulse),     64'd0);
      repeat (2) @(negedge nocclk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic step(input logic iv, input flit_t f, input logic ordy, input logic ack);
      int   sz;
      logic exp_v, do_pop;
      @(negedge nocclk);
      exp_v = (m_offer >= 0) && (cyc >= m_offer);
      check("count",     64'(count),          64'(m_q.size()));
      check("in_ready",  64'(flit_in_ready),  64'(m_q.size() < DEPTH));
      check("out_valid", 64'(flit_out_valid), 64'(exp_v));
      check("drop",      64'(drop_pulse),     64'(cyc == m_drop_at));
      if (exp_v) check("flit_out", 64'(flit_out), 64'(m_q[0]));
      if (flit_out_valid === 1'b1) begin
         n_vcyc++;
         if (ordy) begin
            n_hs++;
            hs_flit     = flit_t'(flit_out);
            last_hs_cyc = cyc;
         end
      end
      if (drop_pulse === 1'b1) n_drop++;

      flit_in_valid  = iv;
      flit_in_s      = f;
      flit_out_ready = ordy;
      ack_valid      = ack;

      sz     = m_q.size();
      do_pop = 1'b0;
      if (m_hs >= 0) begin
         if (ack) do_pop = 1'b1;
         else if (cyc == m_hs + T) begin
            if (m_sends <= MR) begin
               m_offer = cyc + 1;
               m_hs    = -1;
            end else begin
               do_pop    = 1'b1;
               m_drop_at = cyc + 1;
            end
         end
      end else if (m_offer >= 0) begin
         if (ordy) begin
            m_hs    = cyc;
            m_sends++;
            m_offer = -1;
         end
      end else if (sz > 0) begin
         m_offer = cyc + 1;
         m_sends = 0;
      end
      if (do_pop) begin
         void'(m_q.pop_front());
         m_hs    = -1;
         m_sends = 0;
         m_offer = (sz == 1) ? -1 : cyc + 1;
      end
      if (iv && sz < DEPTH) m_q.push_back(f);
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, first_hs, plan_ack;
      logic ack;
      zf = '0;

      // Reset state
      apply_reset();

      // Basic ack path
      clr_stats();
      step(1'b1, mk_flit(8'h05, 32'h0000_00A0), 1'b1, 1'b0);
      b = 0;
      while (m_hs < 0 && b < 10) begin step(1'b0, zf, 1'b1, 1'b0); b++; end
      step(1'b0, zf, 1'b0, 1'b0);
      step(1'b0, zf, 1'b0, 1'b0);
      step(1'b0, zf, 1'b0, 1'b1);
      repeat (3) step(1'b0, zf, 1'b0, 1'b0);
      check("basic_valid_cycles", 64'(n_vcyc), 64'd1);
      check("basic_handshakes",   64'(n_hs),   64'd1);
      check("basic_drops",        64'(n_drop), 64'd0);
      check("basic_count",        64'(count),  64'd0);

      // Timeout retry then drop
      clr_stats();
      step(1'b1, mk_flit(8'h22, 32'h0000_00B1), 1'b1, 1'b0);
      repeat (25) step(1'b0, zf, 1'b1, 1'b0);
      check("retry_handshakes", 64'(n_hs),   64'(MR + 1));
      check("retry_drops",      64'(n_drop), 64'd1);
      check("retry_count",      64'(count),  64'd0);

      // Ack on the final timeout cycle of the last retry
      clr_stats();
      step(1'b1, mk_flit(8'h33, 32'h0000_00C2), 1'b1, 1'b0);
      b = 0;
      while (!(m_hs >= 0 && m_sends == MR + 1) && b < 40) begin step(1'b0, zf, 1'b1, 1'b0); b++; end
      while (m_hs >= 0 && cyc != m_hs + T && b < 60) begin step(1'b0, zf, 1'b1, 1'b0); b++; end
      step(1'b0, zf, 1'b1, 1'b1);
      repeat (4) step(1'b0, zf, 1'b1, 1'b0);
      check("lastack_handshakes", 64'(n_hs),   64'(MR + 1));
      check("lastack_drops",      64'(n_drop), 64'd0);
      check("lastack_count",      64'(count),  64'd0);

      // Full / backpressure, order preserved across pointer wrap
      clr_stats();
      for (int i = 0; i < 5; i++) step(1'b1, mk_flit(8'h40 + 8'(i), 32'(i + 1)), 1'b0, 1'b0);
      step(1'b0, zf, 1'b0, 1'b0);
      check("full_count",    64'(count),         64'd4);
      check("full_in_ready", 64'(flit_in_ready), 64'd0);
      for (int k = 0; k < 4; k++) begin
         b = 0;
         do begin step(1'b0, zf, 1'b1, 1'b0); b++; end while (m_hs < 0 && b < 10);
         check("full_order", 64'(hs_flit.payload), 64'(k + 1));
         step(1'b0, zf, 1'b0, 1'b1);
      end
      step(1'b0, zf, 1'b0, 1'b0);
      check("full_drain_count", 64'(count), 64'd0);

      // Back-to-back with immediate acks
      clr_stats();
      for (int i = 0; i < 3; i++) step(1'b1, mk_flit(8'h50 + 8'(i), 32'h100 + 32'(i)), 1'b0, 1'b0);
      first_hs = -1;
      for (int k = 0; k < 3; k++) begin
         b = 0;
         do begin step(1'b0, zf, 1'b1, 1'b0); b++; end while (m_hs < 0 && b < 10);
         if (first_hs < 0) first_hs = last_hs_cyc;
         check("b2b_order", 64'(hs_flit.payload), 64'(32'h100 + k));
         step(1'b0, zf, 1'b0, 1'b1);
      end
      check("b2b_span", 64'(last_hs_cyc - first_hs), 64'd4);
      step(1'b0, zf, 1'b0, 1'b0);
      check("b2b_count", 64'(count), 64'd0);

      // Reset during WAIT with two flits queued; a late ack must be ignored
      clr_stats();
      step(1'b1, mk_flit(8'h61, 32'h61), 1'b0, 1'b0);
      step(1'b1, mk_flit(8'h62, 32'h62), 1'b0, 1'b0);
      b = 0;
      do begin step(1'b0, zf, 1'b1, 1'b0); b++; end while (m_hs < 0 && b < 10);
      step(1'b0, zf, 1'b0, 1'b0);
      check("midrst_count_before", 64'(count), 64'd2);
      #2;
      apply_reset();
      step(1'b0, zf, 1'b0, 1'b1);
      repeat (3) step(1'b0, zf, 1'b0, 1'b0);
      check("midrst_drops", 64'(n_drop), 64'd0);

      // Randomized traffic with acks planned anywhere in the window or omitted
      plan_ack = -1;
      repeat (600) begin
         if (m_hs >= 0) ack = (cyc == plan_ack);
         else           ack = ($urandom_range(7, 0) == 0);
         step(1'($urandom_range(1, 0)), rnd_flit(), ($urandom_range(3, 0) != 0), ack);
         if (m_hs >= 0 && m_hs == cyc - 1)
            plan_ack = ($urandom_range(2, 0) != 0) ? m_hs + int'($urandom_range(T, 1)) : -1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
